// File: rtl/npu_synchronization_defines.sv
// Shared synchronization types: account message layout and barrier count per tile.
package npu_synchronization_defines;

  localparam int BARRIER_NUMB_FOR_TILE = 16;

  typedef struct packed {
    logic [$clog2(BARRIER_NUMB_FOR_TILE)-1:0] id_barrier;
  } sync_account_message_t;

endpackage

// File: rtl/sync_account_scheduler_pkg.sv
// Scheduler-local constants and the barrier-index helper shared by top and bench.
package sync_account_scheduler_pkg;

  import npu_synchronization_defines::*;

  localparam int BARRIER_IDX_W = $clog2(BARRIER_NUMB_FOR_TILE);

  // Hazard key: low bits of the barrier id select the barrier slot on this tile.
  function automatic logic [BARRIER_IDX_W-1:0] barrier_index(input sync_account_message_t mess);
    return mess.id_barrier[BARRIER_IDX_W-1:0];
  endfunction

endpackage

// File: rtl/sync_account_fifo.sv
// Per-requester input buffer: registered not-full ready, combinational head view.
module sync_account_fifo
  import npu_synchronization_defines::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_valid,
  input  sync_account_message_t push_mess,
  output logic                  push_ready,
  input  logic                  pop,
  output sync_account_message_t head,
  output logic                  empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sync_account_message_t mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_next;
  logic                  push_ok;
  logic                  pop_ok;

  // A full buffer has ready low for the whole cycle, so a same-cycle pop cannot make room for a push.
  assign push_ok    = push_valid && push_ready;
  assign pop_ok     = pop && (count != '0);
  assign count_next = count + CNT_W'(push_ok) - CNT_W'(pop_ok);
  assign empty      = (count == '0);
  assign head       = mem[rd_ptr];

  // Pointer, occupancy and registered-ready bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      push_ready <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count      <= count_next;
      push_ready <= (count_next != CNT_W'(DEPTH));
    end
  end

  // Storage array; contents are meaningless until the matching count says otherwise.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_mess;
  end

endmodule

// File: rtl/sync_account_scheduler.sv
// Two-requester account scheduler: round-robin issue gated by an in-order
// barrier-index scoreboard, with a sticky error on out-of-order retirement.
module sync_account_scheduler
  import npu_synchronization_defines::*;
  import sync_account_scheduler_pkg::*;
#(
  parameter int TILE_ID    = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int INFLIGHT   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  net_account_valid,
  input  sync_account_message_t net_account_mess,
  output logic                  net_account_ready,
  input  logic                  core_account_valid,
  input  sync_account_message_t core_account_mess,
  output logic                  core_account_ready,
  output logic                  sched_account_valid,
  output sync_account_message_t sched_account_mess,
  input  logic                  ss3_account_pending_valid,
  input  sync_account_message_t ss3_account_pending,
  output logic                  sched_busy,
  output logic                  sched_error
);

  localparam int SB_PTR_W = (INFLIGHT > 1) ? $clog2(INFLIGHT) : 1;
  localparam int SB_CNT_W = $clog2(INFLIGHT + 1);

  typedef logic [BARRIER_IDX_W-1:0] bidx_t;

  function automatic logic [SB_PTR_W-1:0] sb_advance(input logic [SB_PTR_W-1:0] ptr);
    return (ptr == SB_PTR_W'(INFLIGHT - 1)) ? '0 : ptr + 1'b1;
  endfunction

  sync_account_message_t net_head;
  sync_account_message_t core_head;
  logic                  net_empty;
  logic                  core_empty;

  bidx_t                 sb_idx [INFLIGHT];
  logic [INFLIGHT-1:0]   sb_vld;
  logic [SB_PTR_W-1:0]   sb_rd_ptr;
  logic [SB_PTR_W-1:0]   sb_wr_ptr;
  logic [SB_CNT_W-1:0]   sb_count;
  logic                  sb_full;
  logic                  sb_empty;

  logic                  net_hazard;
  logic                  core_hazard;
  logic                  net_elig;
  logic                  core_elig;
  logic                  grant_net;
  logic                  grant_core;
  logic                  grant_any;
  bidx_t                 grant_idx;
  logic                  last_core;
  logic                  retire_pop;
  logic                  retire_fault;

  sync_account_fifo #(.DEPTH(FIFO_DEPTH)) u_net_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_valid (net_account_valid),
    .push_mess  (net_account_mess),
    .push_ready (net_account_ready),
    .pop        (grant_net),
    .head       (net_head),
    .empty      (net_empty)
  );

  sync_account_fifo #(.DEPTH(FIFO_DEPTH)) u_core_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_valid (core_account_valid),
    .push_mess  (core_account_mess),
    .push_ready (core_account_ready),
    .pop        (grant_core),
    .head       (core_head),
    .empty      (core_empty)
  );

  assign sb_full  = (sb_count == SB_CNT_W'(INFLIGHT));
  assign sb_empty = (sb_count == '0);

  // Hazard search against registered scoreboard state, so an entry retiring this cycle still blocks.
  always_comb begin
    net_hazard  = 1'b0;
    core_hazard = 1'b0;
    for (int i = 0; i < INFLIGHT; i++) begin
      if (sb_vld[i] && (sb_idx[i] == barrier_index(net_head)))  net_hazard  = 1'b1;
      if (sb_vld[i] && (sb_idx[i] == barrier_index(core_head))) core_hazard = 1'b1;
    end
  end

  // Round-robin: on a tie the requester not granted last wins; each side is judged independently.
  always_comb begin
    net_elig   = !net_empty  && !sb_full && !net_hazard;
    core_elig  = !core_empty && !sb_full && !core_hazard;
    grant_net  = net_elig && (!core_elig || last_core);
    grant_core = core_elig && !grant_net;
    grant_any  = grant_net || grant_core;
    grant_idx  = grant_net ? barrier_index(net_head) : barrier_index(core_head);
  end

  assign retire_pop   = ss3_account_pending_valid && !sb_empty;
  assign retire_fault = ss3_account_pending_valid &&
                        (sb_empty || (barrier_index(ss3_account_pending) != sb_idx[sb_rd_ptr]));

  // Busy reflects occupancy of either buffer or the scoreboard.
  assign sched_busy = !net_empty || !core_empty || !sb_empty;

  // Control state: issue strobe, round-robin history, scoreboard pointers/valids, sticky error.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sched_account_valid <= 1'b0;
      last_core           <= 1'b1;
      sched_error         <= 1'b0;
      sb_rd_ptr           <= '0;
      sb_wr_ptr           <= '0;
      sb_count            <= '0;
      sb_vld              <= '0;
    end else begin
      sched_account_valid <= grant_any;
      if (grant_net)  last_core <= 1'b0;
      if (grant_core) last_core <= 1'b1;
      if (retire_fault) sched_error <= 1'b1;
      if (retire_pop) begin
        sb_vld[sb_rd_ptr] <= 1'b0;
        sb_rd_ptr         <= sb_advance(sb_rd_ptr);
      end
      if (grant_any) begin
        sb_vld[sb_wr_ptr] <= 1'b1;
        sb_wr_ptr         <= sb_advance(sb_wr_ptr);
      end
      sb_count <= sb_count + SB_CNT_W'(grant_any) - SB_CNT_W'(retire_pop);
    end
  end

  // Datapath: issued message and scoreboard index captured on grant; held otherwise.
  always_ff @(posedge clk) begin
    if (grant_any) begin
      sched_account_mess  <= grant_net ? net_head : core_head;
      sb_idx[sb_wr_ptr]   <= grant_idx;
    end
  end

endmodule

// File: tb/tb_sync_account_scheduler.sv
// Directed bench for sync_account_scheduler: latency, round-robin, hazards,
// in-flight limit, retirement errors, buffer full and mid-stream reset.
module tb_sync_account_scheduler;
  import npu_synchronization_defines::*;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  net_account_valid = 1'b0;
  sync_account_message_t net_account_mess = '0;
  logic                  net_account_ready;
  logic                  core_account_valid = 1'b0;
  sync_account_message_t core_account_mess = '0;
  logic                  core_account_ready;
  logic                  sched_account_valid;
  sync_account_message_t sched_account_mess;
  logic                  ss3_account_pending_valid = 1'b0;
  sync_account_message_t ss3_account_pending = '0;
  logic                  sched_busy;
  logic                  sched_error;

  int vectors = 0;
  int miscompares = 0;

  sync_account_scheduler #(.TILE_ID(0), .FIFO_DEPTH(4), .INFLIGHT(3)) dut (
    .clk                       (clk),
    .reset                     (reset),
    .net_account_valid         (net_account_valid),
    .net_account_mess          (net_account_mess),
    .net_account_ready         (net_account_ready),
    .core_account_valid        (core_account_valid),
    .core_account_mess         (core_account_mess),
    .core_account_ready        (core_account_ready),
    .sched_account_valid       (sched_account_valid),
    .sched_account_mess        (sched_account_mess),
    .ss3_account_pending_valid (ss3_account_pending_valid),
    .ss3_account_pending       (ss3_account_pending),
    .sched_busy                (sched_busy),
    .sched_error               (sched_error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic retire(input int id);
    ss3_account_pending_valid = 1'b1;
    ss3_account_pending.id_barrier = 4'(id);
    tick();
    ss3_account_pending_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    vectors++; if (sched_account_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b want=0", sched_account_valid); end
    vectors++; if (net_account_ready !== 1'b1) begin miscompares++; $display("FAIL reset_net_ready got=%b want=1", net_account_ready); end
    vectors++; if (core_account_ready !== 1'b1) begin miscompares++; $display("FAIL reset_core_ready got=%b want=1", core_account_ready); end
    vectors++; if (sched_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b want=0", sched_busy); end
    vectors++; if (sched_error !== 1'b0) begin miscompares++; $display("FAIL reset_error got=%b want=0", sched_error); end
    reset = 1'b1;
    tick();
    vectors++; if (sched_account_valid !== 1'b0) begin miscompares++; $display("FAIL release_valid got=%b want=0", sched_account_valid); end
  endtask

  task automatic test_single_issue();
    net_account_valid = 1'b1; net_account_mess.id_barrier = 4'd5;
    tick();
    net_account_valid = 1'b0;
    vectors++; if (sched_account_valid !== 1'b0) begin miscompares++; $display("FAIL single_early got=%b want=0", sched_account_valid); end
    tick();
    vectors++; if (sched_account_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid got=%b want=1", sched_account_valid); end
    vectors++; if (sched_account_mess.id_barrier !== 4'd5) begin miscompares++; $display("FAIL single_id got=%0d want=5", sched_account_mess.id_barrier); end
    vectors++; if (sched_busy !== 1'b1) begin miscompares++; $display("FAIL single_busy got=%b want=1", sched_busy); end
    tick();
    vectors++; if (sched_account_valid !== 1'b0) begin miscompares++; $display("FAIL single_pulse got=%b want=0", sched_account_valid); end
    vectors++; if (sched_account_mess.id_barrier !== 4'd5) begin miscompares++; $display("FAIL single_hold got=%0d want=5", sched_account_mess.id_barrier); end
    retire(5);
    vectors++; if (sched_error !== 1'b0) begin miscompares++; $display("FAIL single_retire_err got=%b want=0", sched_error); end
    vectors++; if (sched_busy !== 1'b0) begin miscompares++; $display("FAIL single_idle got=%b want=0", sched_busy); end
  endtask

  task automatic test_round_robin();
    int exp_ids [6];
    exp_ids = '{3, 7, 1, 8, 2, 9};
    do_reset();
    net_account_valid = 1'b1;  net_account_mess.id_barrier  = 4'd3;
    core_account_valid = 1'b1; core_account_mess.id_barrier = 4'd7;
    tick();
    net_account_valid = 1'b0; core_account_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++; if (sched_account_valid !== 1'b1 || sched_account_mess.id_barrier !== 4'(exp_ids[k])) begin
        miscompares++; $display("FAIL rr_tie%0d got=%b/%0d want=1/%0d", k, sched_account_valid, sched_account_mess.id_barrier, exp_ids[k]);
      end
    end
    retire(3);
    retire(7);
    net_account_valid = 1'b1;  net_account_mess.id_barrier  = 4'd1;
    core_account_valid = 1'b1; core_account_mess.id_barrier = 4'd8;
    tick();
    net_account_mess.id_barrier = 4'd2; core_account_mess.id_barrier = 4'd9;
    tick();
    net_account_valid = 1'b0; core_account_valid = 1'b0;
    vectors++; if (sched_account_valid !== 1'b1 || sched_account_mess.id_barrier !== 4'(exp_ids[2])) begin
      miscompares++; $display("FAIL rr_alt2 got=%b/%0d want=1/%0d", sched_account_valid, sched_account_mess.id_barrier, exp_ids[2]);
    end
    for (int k = 3; k < 5; k++) begin
      tick();
      vectors++; if (sched_account_valid !== 1'b1 || sched_account_mess.id_barrier !== 4'(exp_ids[k])) begin
        miscompares++; $display("FAIL rr_alt%0d got=%b/%0d want=1/%0d", k, sched_account_valid, sched_account_mess.id_barrier, exp_ids[k]);
      end
    end
    retire(1);
    vectors++; if (sched_account_valid !== 1'b0) begin miscompares++; $display("FAIL rr_full_hold got=%b want=0", sched_account_valid); end
    tick();
    vectors++; if (sched_account_valid !== 1'b1 || sched_account_mess.id_barrier !== 4'(exp_ids[5])) begin
      miscompares++; $display("FAIL rr_alt5 got=%b/%0d want=1/%0d", sched_account_valid, sched_account_mess.id_barrier, exp_ids[5]);
    end
    retire(8);
    retire(2);
    retire(9);
    vectors++; if (sched_error !== 1'b0 || sched_busy !== 1'b0) begin miscompares++; $display("FAIL rr_drain got=%b/%b want=0/0", sched_error, sched_busy); end
  endtask

  task automatic test_hazard();
    net_account_valid = 1'b1; net_account_mess.id_barrier = 4'd4;
    tick();
    net_account_valid = 1'b0;
    tick();
    vectors++; if (sched_account_valid !== 1'b1 || sched_account_mess.id_barrier !== 4'd4) begin
      miscompares++; $display("FAIL haz_first got=%b/%0d want=1/4", sched_account_valid, sched_account_mess.id_barrier);
    end
    core_account_valid = 1'b1; core_account_mess.id_barrier = 4'd4;
    tick();
    core_account_valid = 1'b0;
    net_account_valid = 1'b1; net_account_mess.id_barrier = 4'd9;
    tick();
    net_account_valid = 1'b0;
    vectors++; if (sched_account_valid !== 1'b0) begin miscompares++; $display("FAIL haz_core_held got=%b want=0", sched_account_valid); end
    tick();
    vectors++; if (sched_account_valid !== 1'b1 || sched_account_mess.id_barrier !== 4'd9) begin
      miscompares++; $display("FAIL haz_bypass got=%b/%0d want=1/9", sched_account_valid, sched_account_mess.id_barrier);
    end
    retire(4);
    vectors++; if (sched_account_valid !== 1'b0) begin miscompares++; $display("FAIL haz_retire_cycle got=%b want=0", sched_account_valid); end
    tick();
    vectors++; if (sched_account_valid !== 1'b1 || sched_account_mess.id_barrier !== 4'd4) begin
      miscompares++; $display("FAIL haz_release got=%b/%0d want=1/4", sched_account_valid, sched_account_mess.id_barrier);
    end
    retire(9);
    retire(4);
    vectors++; if (sched_error !== 1'b0 || sched_busy !== 1'b0) begin miscompares++; $display("FAIL haz_drain got=%b/%b want=0/0", sched_error, sched_busy); end
  endtask

  task automatic test_inflight_limit();
    net_account_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      net_account_mess.id_barrier = 4'(10 + k);
      tick();
      if (k > 0) begin
        vectors++; if (sched_account_valid !== 1'b1 || sched_account_mess.id_barrier !== 4'(9 + k)) begin
          miscompares++; $display("FAIL infl_issue%0d got=%b/%0d want=1/%0d", k, sched_account_valid, sched_account_mess.id_barrier, 9 + k);
        end
      end
    end
    net_account_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++; if (sched_account_valid !== 1'b0) begin miscompares++; $display("FAIL infl_held%0d got=%b want=0", k, sched_account_valid); end
    end
    retire(10);
    vectors++; if (sched_account_valid !== 1'b0) begin miscompares++; $display("FAIL infl_retire_cycle got=%b want=0", sched_account_valid); end
    tick();
    vectors++; if (sched_account_valid !== 1'b1 || sched_account_mess.id_barrier !== 4'd13) begin
      miscompares++; $display("FAIL infl_fourth got=%b/%0d want=1/13", sched_account_valid, sched_account_mess.id_barrier);
    end
    for (int k = 11; k < 14; k++) retire(k);
    vectors++; if (sched_error !== 1'b0 || sched_busy !== 1'b0) begin miscompares++; $display("FAIL infl_drain got=%b/%b want=0/0", sched_error, sched_busy); end
  endtask

  task automatic test_retire_error();
    retire(2);
    vectors++; if (sched_error !== 1'b1) begin miscompares++; $display("FAIL err_empty got=%b want=1", sched_error); end
    tick();
    tick();
    vectors++; if (sched_error !== 1'b1) begin miscompares++; $display("FAIL err_sticky got=%b want=1", sched_error); end
    do_reset();
    vectors++; if (sched_error !== 1'b0) begin miscompares++; $display("FAIL err_cleared got=%b want=0", sched_error); end
    net_account_valid = 1'b1; net_account_mess.id_barrier = 4'd6;
    tick();
    net_account_valid = 1'b0;
    tick();
    retire(2);
    vectors++; if (sched_error !== 1'b1) begin miscompares++; $display("FAIL err_order got=%b want=1", sched_error); end
    vectors++; if (sched_busy !== 1'b0) begin miscompares++; $display("FAIL err_popped got=%b want=0", sched_busy); end
    do_reset();
  endtask

  task automatic test_full_and_reset();
    core_account_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      core_account_mess.id_barrier = 4'(k);
      tick();
    end
    core_account_valid = 1'b0;
    tick();
    tick();
    net_account_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      vectors++; if (net_account_ready !== 1'b1) begin miscompares++; $display("FAIL full_ready%0d got=%b want=1", k, net_account_ready); end
      net_account_mess.id_barrier = 4'(4 + k);
      tick();
    end
    vectors++; if (net_account_ready !== 1'b0) begin miscompares++; $display("FAIL full_not_ready got=%b want=0", net_account_ready); end
    net_account_mess.id_barrier = 4'd8;
    tick();
    vectors++; if (net_account_ready !== 1'b0 || sched_account_valid !== 1'b0) begin
      miscompares++; $display("FAIL full_stuck got=%b/%b want=0/0", net_account_ready, sched_account_valid);
    end
    reset = 1'b0;
    tick();
    net_account_valid = 1'b0;
    vectors++; if (net_account_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready got=%b want=1", net_account_ready); end
    vectors++; if (sched_busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got=%b want=0", sched_busy); end
    vectors++; if (sched_error !== 1'b0) begin miscompares++; $display("FAIL midrst_error got=%b want=0", sched_error); end
    reset = 1'b1;
    tick();
    vectors++; if (sched_account_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_noissue got=%b want=0", sched_account_valid); end
    tick();
    vectors++; if (sched_account_valid !== 1'b0 || sched_busy !== 1'b0) begin
      miscompares++; $display("FAIL midrst_quiet got=%b/%b want=0/0", sched_account_valid, sched_busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_issue();
    test_round_robin();
    test_hazard();
    test_inflight_limit();
    test_retire_error();
    test_full_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
